muldiv_iter: RTL and testbench

- Parametrised iterative multiply/divide engine producing a {hi, lo} pair for the HI/LO register write in the Memory stage.
- Successor to the fixed 32-bit divide-only unit: adds signed/unsigned multiply, a parametric operand width, defined divide-by-zero results, annul, and a combinational pipeline stall output.
- Sits in the Execute stage. Operands come from the forwarded ALU inputs; the result feeds the HI/LO write mux.

---
 rtl/muldiv_iter_if.sv | 34 +++
 rtl/muldiv_iter.sv | 167 ++++++++++++++++
 tb/tb_muldiv_iter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_iter_if.sv
// Handshake/data bundle for the iterative multiply/divide engine.
//   start  : request a new operation (sampled only while the engine is idle)
//   op     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opa    : multiplicand / dividend
//   opb    : multiplier / divisor
//   annul  : abort the operation in flight (Execute flush / exception)
//   busy   : operation in flight
//   stall  : combinational pipeline stall request
//   ready  : one-cycle pulse, result valid
//   result : {hi, lo}; MUL full product, DIV {remainder, quotient}
// The master drives requests (Execute stage); the slave is the engine.
interface muldiv_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic               annul;
  logic               busy;
  logic               stall;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, op, opa, opb, annul,
    input  busy, stall, ready, result
  );

  modport slave (
    input  start, op, opa, opb, annul,
    output busy, stall, ready, result
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide engine producing a {hi, lo} pair for the HI/LO write.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : muldiv_iter_if slave modport (start/op/opa/opb/annul in; busy/stall/ready/result out)
// Operation: IDLE latches the raw operands and sign flags, PREP converts to magnitudes (or
// short-circuits divide-by-zero), ITER runs WIDTH shift-add / restoring-divide steps, FIN
// presents the result for one cycle and commits it unless annulled.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic          clk,
  input logic          rst,
  muldiv_iter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPrep, StIter, StFin} stateE;

  stateE              stateQ;
  logic [1:0]         opQ;
  logic [WIDTH-1:0]   aQ;        // raw opa, then multiplicand magnitude
  logic [WIDTH-1:0]   bQ;        // raw opb, then divisor magnitude
  logic [WIDTH-1:0]   accQ;      // product high half / partial remainder
  logic [WIDTH-1:0]   loQ;       // multiplier -> product low half / dividend -> quotient
  logic [CNT_W-1:0]   cntQ;
  logic               negResQ;   // product / quotient sign
  logic               negRemQ;   // remainder sign (dividend sign)
  logic               busyQ;
  logic [2*WIDTH-1:0] resultQ;

  logic               isDiv;
  logic               isSigned;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic               divFits;
  logic [WIDTH-1:0]   stepHi;
  logic [WIDTH-1:0]   stepLo;
  logic [2*WIDTH-1:0] negProd;
  logic [WIDTH-1:0]   fixHi;
  logic [WIDTH-1:0]   fixLo;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic               readyInt;

  assign isDiv    = opQ[1];
  assign isSigned = ~opQ[0];

  always_comb begin
    // One shift-add step: {acc, lo} >> 1 after conditionally adding the multiplicand.
    mulSum   = {1'b0, accQ} + (loQ[0] ? {1'b0, aQ} : '0);
    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    divShift = {accQ, loQ[WIDTH-1]};
    divDiff  = divShift - {1'b0, bQ};
    divFits  = ~divDiff[WIDTH];
    if (isDiv) begin
      stepHi = divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
      stepLo = {loQ[WIDTH-2:0], divFits};
    end else begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], loQ[WIDTH-1:1]};
    end

    // Sign correction is folded into the last ITER step so FIN can present it directly.
    negProd = '0 - {stepHi, stepLo};
    fixHi   = stepHi;
    fixLo   = stepLo;
    if (isSigned) begin
      if (isDiv) begin
        if (negResQ) fixLo = '0 - stepLo;
        if (negRemQ) fixHi = '0 - stepHi;
      end else if (negResQ) begin
        fixHi = negProd[2*WIDTH-1:WIDTH];
        fixLo = negProd[WIDTH-1:0];
      end
    end

    // Most-negative maps onto itself, which is the correct unsigned magnitude.
    magA = (isSigned && aQ[WIDTH-1]) ? ('0 - aQ) : aQ;
    magB = (isSigned && bQ[WIDTH-1]) ? ('0 - bQ) : bQ;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ  <= StIdle;
      opQ     <= '0;
      aQ      <= '0;
      bQ      <= '0;
      accQ    <= '0;
      loQ     <= '0;
      cntQ    <= '0;
      negResQ <= 1'b0;
      negRemQ <= 1'b0;
      busyQ   <= 1'b0;
      resultQ <= '0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (bus.start && !bus.annul) begin
            opQ     <= bus.op;
            aQ      <= bus.opa;
            bQ      <= bus.opb;
            negResQ <= ~bus.op[0] & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
            negRemQ <= ~bus.op[0] & bus.opa[WIDTH-1];
            busyQ   <= 1'b1;
            stateQ  <= StPrep;
          end
        end
        StPrep: begin
          if (bus.annul) begin
            busyQ  <= 1'b0;
            stateQ <= StIdle;
          end else if (isDiv && (bQ == '0)) begin
            // Defined divide-by-zero result, no sign correction.
            accQ   <= aQ;
            loQ    <= '1;
            stateQ <= StFin;
          end else begin
            accQ   <= '0;
            cntQ   <= CNT_W'(WIDTH);
            stateQ <= StIter;
            if (isDiv) begin
              loQ <= magA;
              bQ  <= magB;
            end else begin
              aQ  <= magA;
              loQ <= magB;
            end
          end
        end
        StIter: begin
          if (bus.annul) begin
            busyQ  <= 1'b0;
            stateQ <= StIdle;
          end else begin
            cntQ <= cntQ - CNT_W'(1);
            if (cntQ == CNT_W'(1)) begin
              accQ   <= fixHi;
              loQ    <= fixLo;
              stateQ <= StFin;
            end else begin
              accQ <= stepHi;
              loQ  <= stepLo;
            end
          end
        end
        StFin: begin
          busyQ  <= 1'b0;
          stateQ <= StIdle;
          if (!bus.annul) resultQ <= {accQ, loQ};
        end
        default: begin
          busyQ  <= 1'b0;
          stateQ <= StIdle;
        end
      endcase
    end
  end

  // An annul arriving in the FIN cycle withdraws both the pulse and the new value.
  assign readyInt   = (stateQ == StFin) && !bus.annul;
  assign bus.ready  = readyInt;
  assign bus.busy   = busyQ;
  assign bus.result = readyInt ? {accQ, loQ} : resultQ;
  assign bus.stall  = busyQ | (bus.start & ~bus.annul & (stateQ == StIdle));

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;

  logic clk = 1'b0;
  logic rst32 = 1'b0;
  logic rst8 = 1'b0;
  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(32)) b32 ();
  muldiv_iter_if #(.WIDTH(8))  b8 ();

  muldiv_iter #(.WIDTH(32), .CNT_W(6)) u32 (.clk(clk), .rst(rst32), .bus(b32));
  muldiv_iter #(.WIDTH(8),  .CNT_W(4)) u8  (.clk(clk), .rst(rst8),  .bus(b8));

  int nPass = 0;
  int nTotal = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic, returns (hi << w) | lo.
  function automatic longint unsigned model(input int w, input logic [1:0] o,
                                            input longint unsigned a, input longint unsigned b);
    longint unsigned mask, up, hi, lo;
    longint sa, sb, q, r;
    mask = (longint'(1) << w) - 1;
    a = a & mask;
    b = b & mask;
    sa = longint'(a);
    sb = longint'(b);
    if (a[w-1]) sa = sa - (longint'(1) << w);
    if (b[w-1]) sb = sb - (longint'(1) << w);
    hi = 0;
    lo = 0;
    case (o)
      2'd0: begin up = longint'(sa * sb); hi = (up >> w) & mask; lo = up & mask; end
      2'd1: begin up = a * b; hi = (up >> w) & mask; lo = up & mask; end
      2'd2: begin
        if (b == 0) begin hi = a; lo = mask; end
        else begin q = sa / sb; r = sa % sb; hi = longint'(r) & mask; lo = longint'(q) & mask; end
      end
      default: begin
        if (b == 0) begin hi = a; lo = mask; end
        else begin hi = a % b; lo = a / b; end
      end
    endcase
    return (hi << w) | lo;
  endfunction

  // Cycle-level expectation for the 32-bit instance.
  int          cyc = 0;
  int          readyAt = 0;
  logic        mBusy = 1'b0;
  logic [63:0] expRes = '0;
  logic [63:0] heldRes = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst32) begin
      mBusy   <= 1'b0;
      heldRes <= '0;
    end else if (mBusy) begin
      if (b32.annul) mBusy <= 1'b0;
      else if (cyc == readyAt) begin
        mBusy   <= 1'b0;
        heldRes <= expRes;
      end
    end else if (b32.start && !b32.annul) begin
      mBusy   <= 1'b1;
      expRes  <= model(32, b32.op, 64'(b32.opa), 64'(b32.opb));
      readyAt <= cyc + ((b32.op[1] && b32.opb == 0) ? 2 : 34);
    end
  end

  always @(negedge clk) begin
    if (rst32) begin
      chk("busy", 64'(b32.busy), 64'(mBusy));
      chk("ready", 64'(b32.ready), 64'(mBusy && cyc == readyAt && !b32.annul));
      chk("result", b32.result, (mBusy && cyc == readyAt && !b32.annul) ? expRes : heldRes);
      chk("stall", 64'(b32.stall), 64'(mBusy | (b32.start & ~b32.annul)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; b2b starts it in the current (ready) cycle so it is accepted next cycle.
  task automatic doOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input bit b2b, input int hold, output int lat, output logic [63:0] res);
    if (b2b) #1;
    else tick();
    b32.start = 1'b1;
    b32.op    = o;
    b32.opa   = a;
    b32.opb   = b;
    if (b2b) tick();
    lat = -1;
    res = '0;
    for (int n = 1; n < 100; n++) begin
      tick();
      if (n >= hold) b32.start = 1'b0;
      b32.opa = $urandom;
      b32.opb = $urandom;
      @(negedge clk);
      if (b32.ready) begin
        lat = n;
        res = b32.result;
        break;
      end
    end
    if (lat < 0) chk("readyTimeout", 64'(0), 64'(1));
  endtask

  task automatic annulRun(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int k);
    tick();
    b32.start = 1'b1;
    b32.op    = o;
    b32.opa   = a;
    b32.opb   = b;
    for (int n = 1; n <= k; n++) begin
      tick();
      b32.start = 1'b0;
      if (n == k) b32.annul = 1'b1;
    end
    tick();
    b32.annul = 1'b0;
    @(negedge clk);
    chk("busyAfterAnnul", 64'(b32.busy), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [63:0] res;
    logic [1:0]  o;
    logic [31:0] a, b;

    b32.start = 0; b32.op = 0; b32.opa = 0; b32.opb = 0; b32.annul = 0;
    b8.start = 0;  b8.op = 0;  b8.opa = 0;  b8.opb = 0;  b8.annul = 0;

    // Pin the reference itself.
    chk("modelMult", model(32, 0, 32'hFFFFFFFD, 5), 64'hFFFFFFFF_FFFFFFF1);
    chk("modelMultu", model(32, 1, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    chk("modelDivu", model(32, 3, 100, 7), 64'h00000002_0000000E);
    chk("modelDiv", model(32, 2, 32'hFFFFFFF9, 2), 64'hFFFFFFFF_FFFFFFFD);
    chk("modelDivOvf", model(32, 2, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    chk("modelDiv0", model(32, 2, 32'hFFFFFFF0, 0), 64'hFFFFFFF0_FFFFFFFF);
    chk("modelDiv8", model(8, 2, 8'h9C, 8'h07), 64'h0000_0000_0000_FEF2);

    #1;
    chk("rstBusy", 64'(b32.busy), 64'(0));
    chk("rstReady", 64'(b32.ready), 64'(0));
    chk("rstResult", b32.result, 64'(0));
    chk("rstResult8", 64'(b8.result), 64'(0));
    tick(); tick();
    rst32 = 1'b1;
    rst8  = 1'b1;

    // start with annul in IDLE is ignored.
    tick();
    b32.start = 1'b1;
    b32.annul = 1'b1;
    @(negedge clk);
    chk("stallAnnulIdle", 64'(b32.stall), 64'(0));
    tick();
    b32.start = 1'b0;
    b32.annul = 1'b0;
    @(negedge clk);
    chk("idleAfterAnnulStart", 64'(b32.busy), 64'(0));

    doOp(2'd0, 32'hFFFFFFFD, 32'd5, 1'b0, 1, lat, res);
    chk("multLat", 64'(lat), 64'(34));
    chk("multRes", res, 64'hFFFFFFFF_FFFFFFF1);
    doOp(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1, lat, res);
    chk("multuRes", res, 64'hFFFFFFFE_00000001);
    doOp(2'd3, 32'd100, 32'd7, 1'b1, 1, lat, res);
    chk("divuB2bLat", 64'(lat), 64'(34));
    chk("divuB2bRes", res, 64'h00000002_0000000E);
    doOp(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1, lat, res);
    chk("divRes", res, 64'hFFFFFFFF_FFFFFFFD);
    doOp(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1, lat, res);
    chk("divOvfRes", res, 64'h00000000_80000000);
    doOp(2'd3, 32'h1234, 32'd0, 1'b0, 1, lat, res);
    chk("divu0Lat", 64'(lat), 64'(2));
    chk("divu0Res", res, 64'h00001234_FFFFFFFF);
    doOp(2'd2, 32'hFFFFFFF0, 32'd0, 1'b0, 1, lat, res);
    chk("div0Lat", 64'(lat), 64'(2));
    chk("div0Res", res, 64'hFFFFFFF0_FFFFFFFF);

    annulRun(2'd1, 32'd3, 32'd4, 10);
    chk("annulKeepsResult", b32.result, 64'hFFFFFFF0_FFFFFFFF);
    doOp(2'd1, 32'd3, 32'd4, 1'b0, 6, lat, res);
    chk("multuAfterAnnul", res, 64'h0000000C);
    chk("heldStartLat", 64'(lat), 64'(34));
    repeat (3) @(negedge clk);
    chk("noQueuedStart", 64'(b32.busy), 64'(0));

    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = 32'($urandom);
      endcase
      doOp(o, a, b, 1'($urandom_range(0, 1)), 1, lat, res);
      chk("randLat", 64'(lat), 64'((o[1] && b == 0) ? 2 : 34));
      chk("randRes", res, model(32, o, 64'(a), 64'(b)));
    end

    for (int i = 0; i < 16; i++) begin
      annulRun(2'($urandom_range(0, 3)), 32'($urandom), 32'($urandom_range(0, 3)),
               int'($urandom_range(1, 36)));
    end

    // Narrow instance: signed divide and asynchronous reset mid-iteration.
    tick();
    b8.start = 1'b1; b8.op = 2'd2; b8.opa = 8'h9C; b8.opb = 8'h07;
    lat = -1;
    for (int n = 1; n < 40; n++) begin
      tick();
      b8.start = 1'b0;
      b8.opa = 8'($urandom);
      @(negedge clk);
      if (b8.ready) begin lat = n; chk("div8Res", 64'(b8.result), 64'h0000_FEF2); break; end
    end
    chk("div8Lat", 64'(lat), 64'(10));
    tick();
    b8.start = 1'b1; b8.op = 2'd1; b8.opa = 8'hF3; b8.opb = 8'h11;
    for (int n = 1; n <= 5; n++) begin
      tick();
      b8.start = 1'b0;
    end
    rst8 = 1'b0;
    #1;
    chk("rst8Busy", 64'(b8.busy), 64'(0));
    chk("rst8Ready", 64'(b8.ready), 64'(0));
    chk("rst8Result", 64'(b8.result), 64'(0));
    tick();
    rst8 = 1'b1;
    lat = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (b8.ready || b8.busy) lat = 1;
    end
    chk("rst8NoPulse", 64'(lat), 64'(0));

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
